// File: rtl/mprj_io_sig_checker.sv
// mprj_io_sig_checker: qualifies firmware checkpoint markers on mprj_io and folds strobed bytes into a CRC-16 verdict
module mprj_io_sig_checker #(
    parameter logic [15:0] START_MARK = 16'hAB60,
    parameter logic [15:0] END_MARK   = 16'hAB6F,
    parameter int unsigned STABLE     = 4,
    parameter logic [15:0] POLY       = 16'h1021,
    parameter logic [15:0] EXP_SIG    = 16'hEFDF,
    parameter logic [15:0] EXP_COUNT  = 16'd1,
    parameter logic [31:0] TIMEOUT    = 32'd100000
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic [37:0] mprj_io,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic [15:0] byte_count,
    output logic [15:0] signature,
    output logic [1:0]  state
);
    typedef enum logic [1:0] {WAIT_START = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;
    localparam logic [3:0] STAB_HIT = 4'(STABLE - 1);
    state_t st, st_next;
    logic [37:0] io_q, io_qq;
    logic [3:0]  stab_cnt;
    logic [31:0] to_cnt;
    logic [15:0] sig_next, cnt_next, crc;
    logic        done_next, pass_next, to_next, tog, seen_start, seen_end, to_hit;
    logic        unused_pads;
    assign unused_pads = ^{io_q[37:32], io_q[6:0], io_qq[37:32], io_qq[15:8], io_qq[6:0]};
    assign state      = st;
    assign tog        = io_q[7] ^ io_qq[7];
    assign seen_start = (io_q[31:16] == START_MARK) && (stab_cnt == STAB_HIT);
    assign seen_end   = (io_q[31:16] == END_MARK) && (stab_cnt == STAB_HIT);
    assign to_hit     = (st != DONE) && (to_cnt == TIMEOUT - 32'd1);
    assign crc        = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : 16'h0000) ^ {8'h00, io_q[15:8]};
    // next-state, signature/count update and verdict; timeout overrides everything
    always_comb begin
        st_next   = st;
        sig_next  = signature;
        cnt_next  = byte_count;
        done_next = done;
        pass_next = pass;
        to_next   = timed_out;
        if (st == WAIT_START && seen_start) begin
            st_next  = CAPTURE;
            sig_next = 16'hFFFF;
            cnt_next = 16'd0;
        end
        if (st == CAPTURE && tog) begin
            sig_next = crc;
            cnt_next = &byte_count ? byte_count : byte_count + 16'd1;
        end
        if (st == CAPTURE && seen_end) begin
            st_next   = DONE;
            done_next = 1'b1;
            pass_next = (sig_next == EXP_SIG) && (cnt_next == EXP_COUNT);
        end
        if (to_hit) begin
            st_next   = DONE;
            done_next = 1'b1;
            to_next   = 1'b1;
            pass_next = 1'b0;
        end
    end
    // pad sampling, marker stability qualifier, timeout counter and state registers
    always_ff @(posedge clock) begin
        if (!resetb) begin
            io_q       <= '0;
            io_qq      <= '0;
            stab_cnt   <= '0;
            to_cnt     <= '0;
            st         <= WAIT_START;
            signature  <= 16'hFFFF;
            byte_count <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            io_q       <= mprj_io;
            io_qq      <= io_q;
            stab_cnt   <= (io_q[31:16] == io_qq[31:16]) ? ((&stab_cnt) ? stab_cnt : stab_cnt + 4'd1) : 4'd0;
            to_cnt     <= (st != DONE) ? to_cnt + 32'd1 : to_cnt;
            st         <= st_next;
            signature  <= sig_next;
            byte_count <= cnt_next;
            done       <= done_next;
            pass       <= pass_next;
            timed_out  <= to_next;
        end
    end
endmodule

// File: tb/tb_mprj_io_sig_checker.sv
// tb_mprj_io_sig_checker: directed checks of marker qualification, CRC folding, verdict, timeout and reset
module tb_mprj_io_sig_checker;
    logic        clock, resetb;
    logic [37:0] mprj_io;
    logic [15:0] cur_mark;
    logic [7:0]  cur_data;
    logic        cur_strb;
    logic        done, pass, timed_out;
    logic [15:0] byte_count, signature;
    logic [1:0]  state;
    int          n_chk, n_fail;
    localparam logic [15:0] SM = 16'hAB60;
    localparam logic [15:0] EM = 16'hAB6F;
    assign mprj_io = {6'b0, cur_mark, cur_data, cur_strb, 7'b0};
    mprj_io_sig_checker #(.TIMEOUT(32'd200)) dut (
        .clock(clock), .resetb(resetb), .mprj_io(mprj_io), .done(done), .pass(pass),
        .timed_out(timed_out), .byte_count(byte_count), .signature(signature), .state(state)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        cur_mark = 16'h0000;
        cur_data = 8'h00;
        cur_strb = 1'b0;
        resetb = 1'b0;
        tick(2);
        resetb = 1'b1;
    endtask
    task automatic strobe(input logic [7:0] d);
        cur_data = d;
        cur_strb = ~cur_strb;
        tick(2);
    endtask
    initial begin
        n_chk = 0;
        n_fail = 0;
        do_reset();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_to", 32'(timed_out), 32'd0);
        chk("rst_cnt", 32'(byte_count), 32'd0);
        chk("rst_sig", 32'(signature), 32'hFFFF);
        // one byte 00 -> pass
        cur_mark = SM;
        tick(5);
        chk("t1_no_early_start", 32'(state), 32'd0);
        tick(1);
        chk("t1_capture", 32'(state), 32'd1);
        strobe(8'h00);
        chk("t1_cnt_mid", 32'(byte_count), 32'd1);
        chk("t1_sig_mid", 32'(signature), 32'hEFDF);
        cur_mark = EM;
        tick(6);
        chk("t1_state", 32'(state), 32'd2);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_to", 32'(timed_out), 32'd0);
        chk("t1_sig", 32'(signature), 32'hEFDF);
        // two bytes -> count mismatch
        do_reset();
        cur_mark = SM;
        tick(6);
        strobe(8'h00);
        strobe(8'h00);
        cur_mark = EM;
        tick(6);
        chk("t2_sig", 32'(signature), 32'hCF9F);
        chk("t2_cnt", 32'(byte_count), 32'd2);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_pass", 32'(pass), 32'd0);
        // short START glitch is never accepted
        do_reset();
        cur_mark = SM;
        tick(2);
        cur_mark = 16'h0000;
        tick(6);
        chk("t3_state", 32'(state), 32'd0);
        strobe(8'h55);
        tick(1);
        chk("t3_cnt", 32'(byte_count), 32'd0);
        chk("t3_sig", 32'(signature), 32'hFFFF);
        // strobe coincides with END qualification
        do_reset();
        cur_mark = SM;
        tick(6);
        cur_mark = EM;
        tick(4);
        cur_data = 8'hA5;
        cur_strb = ~cur_strb;
        tick(1);
        chk("t4_pre_state", 32'(state), 32'd1);
        chk("t4_pre_cnt", 32'(byte_count), 32'd0);
        tick(1);
        chk("t4_state", 32'(state), 32'd2);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_cnt", 32'(byte_count), 32'd1);
        chk("t4_sig", 32'(signature), 32'hEF7A);
        chk("t4_pass", 32'(pass), 32'd0);
        // reset mid-capture discards the window
        do_reset();
        cur_mark = SM;
        tick(6);
        strobe(8'h01);
        strobe(8'h02);
        strobe(8'h03);
        chk("t6_cnt_pre", 32'(byte_count), 32'd3);
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
        chk("t6_state", 32'(state), 32'd0);
        chk("t6_cnt", 32'(byte_count), 32'd0);
        chk("t6_sig", 32'(signature), 32'hFFFF);
        chk("t6_done", 32'(done), 32'd0);
        // timeout at 200 cycles after reset, late END ignored
        do_reset();
        cur_mark = SM;
        tick(6);
        tick(193);
        chk("t5_not_yet", 32'(done), 32'd0);
        chk("t5_state_cap", 32'(state), 32'd1);
        tick(1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_to", 32'(timed_out), 32'd1);
        chk("t5_pass", 32'(pass), 32'd0);
        chk("t5_state", 32'(state), 32'd2);
        cur_mark = EM;
        tick(6);
        chk("t5_state_late", 32'(state), 32'd2);
        chk("t5_to_late", 32'(timed_out), 32'd1);
        chk("t5_pass_late", 32'(pass), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
